// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and its decoder interface.
package fetch_pkg;

  localparam int unsigned FETCH_PC_W     = 32;
  localparam int unsigned FETCH_INS_W    = 32;
  localparam int unsigned FETCH_INS_SIZE = 4;
  localparam int unsigned PERF_W         = 32;

  typedef enum logic [1:0] {
    decoder_nope = 2'd0,
    decoder_keep = 2'd1,
    decoder_next = 2'd2
  } decoder_state_t;

  typedef struct packed {
    decoder_state_t               decoder_state;
    logic [FETCH_INS_W-1:0]       inst;
    logic [FETCH_PC_W-1:0]        pc;
  } fetch_to_decoder_req_t;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2
  } fetch_state_t;

  // Saturating increment for performance counters.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == '1) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {inst, pc} buffer that parks a response while the backend stalls.
module fetch_hold_buf
  import fetch_pkg::*;
#(
  parameter int unsigned INS_W = FETCH_INS_W,
  parameter int unsigned PC_W  = FETCH_PC_W
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [INS_W-1:0] push_inst,
  input  logic [PC_W-1:0]  push_pc,
  output logic             full,
  output logic [INS_W-1:0] inst,
  output logic [PC_W-1:0]  pc
);

  // Flush wins over push; push and pop never coincide since a full buffer blocks requests.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      full <= 1'b0;
      inst <= '0;
      pc   <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
      inst <= push_inst;
      pc   <= push_pc;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Front-end fetch stage: owns the PC, issues one imem request at a time,
// absorbs backend stalls in a one-entry hold buffer and applies branch redirects.
// Optional feature macro: FETCH_PERF_CNT_EN (adds perf_fetched_o / perf_bubbles_o).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      PC_W     = FETCH_PC_W,
  parameter int unsigned      INS_W    = FETCH_INS_W,
  parameter int unsigned      INS_SIZE = FETCH_INS_SIZE,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  arstn,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [PC_W-1:0]       imem_req_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [INS_W-1:0]      imem_rsp_data_i,
  input  logic                  stall_i,
  input  logic                  branch_valid_i,
  input  logic [PC_W-1:0]       branch_target_i,
  output fetch_to_decoder_req_t fetch_to_decoder_req_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]     perf_fetched_o,
  output logic [PERF_W-1:0]     perf_bubbles_o
`endif
);

  fetch_state_t     state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  inflight_pc_q;
  logic             kill_q;
  logic             dec_valid_q;

  logic             buf_full;
  logic [INS_W-1:0] buf_inst;
  logic [PC_W-1:0]  buf_pc;
  logic             buf_push;
  logic             buf_pop;

  logic             req_hs;
  logic             rsp_live;
  decoder_state_t   dec_state;
  logic [INS_W-1:0] dec_inst;
  logic [PC_W-1:0]  dec_pc;

  // A killed request is still outstanding, so no new request until its response drains.
  assign imem_req_valid_o = (state_q == S_REQ) && !buf_full && !kill_q;
  assign imem_req_addr_o  = pc_q;
  assign req_hs           = imem_req_valid_o && imem_req_ready_i;
  assign rsp_live         = (state_q == S_WAIT) && imem_rsp_valid_i && !kill_q;

  // Decoder command selection: branch, then stall, then buffered entry, then live response.
  always_comb begin
    dec_state = decoder_nope;
    dec_inst  = '0;
    dec_pc    = '0;
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    if (branch_valid_i) begin
      dec_state = decoder_nope;
    end else if (stall_i) begin
      dec_state = dec_valid_q ? decoder_keep : decoder_nope;
      buf_push  = rsp_live;
    end else if (buf_full) begin
      dec_state = decoder_next;
      dec_inst  = buf_inst;
      dec_pc    = buf_pc;
      buf_pop   = 1'b1;
    end else if (rsp_live) begin
      dec_state = decoder_next;
      dec_inst  = imem_rsp_data_i;
      dec_pc    = inflight_pc_q;
    end
  end

  assign fetch_to_decoder_req_o = '{decoder_state: dec_state,
                                    inst:          FETCH_INS_W'(dec_inst),
                                    pc:            FETCH_PC_W'(dec_pc)};

  fetch_hold_buf #(
    .INS_W (INS_W),
    .PC_W  (PC_W)
  ) u_hold_buf (
    .clk       (clk),
    .arstn     (arstn),
    .push      (buf_push),
    .pop       (buf_pop),
    .flush     (branch_valid_i),
    .push_inst (imem_rsp_data_i),
    .push_pc   (inflight_pc_q),
    .full      (buf_full),
    .inst      (buf_inst),
    .pc        (buf_pc)
  );

  // Fetch FSM, PC, in-flight tracking and kill bookkeeping.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q       <= S_RESET;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
      dec_valid_q   <= 1'b0;
    end else begin
      if (dec_state == decoder_next) begin
        dec_valid_q <= 1'b1;
      end else if (dec_state == decoder_nope) begin
        dec_valid_q <= 1'b0;
      end

      if (req_hs) begin
        inflight_pc_q <= pc_q;
      end

      if (branch_valid_i) begin
        pc_q <= branch_target_i;
      end else if (req_hs) begin
        pc_q <= pc_q + PC_W'(INS_SIZE);
      end

      // Kill survives only while a response is still owed after this cycle.
      kill_q <= (kill_q && !imem_rsp_valid_i) ||
                (branch_valid_i && (req_hs || ((state_q == S_WAIT) && !imem_rsp_valid_i)));

      case (state_q)
        S_RESET: state_q <= S_REQ;
        S_REQ:   if (req_hs && !branch_valid_i) state_q <= S_WAIT;
        S_WAIT:  if (branch_valid_i || imem_rsp_valid_i) state_q <= S_REQ;
        default: state_q <= S_RESET;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating delivery and bubble counters.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      perf_fetched_o <= '0;
      perf_bubbles_o <= '0;
    end else begin
      if (dec_state == decoder_next) begin
        perf_fetched_o <= sat_inc(perf_fetched_o);
      end
      if ((dec_state == decoder_nope) && (state_q != S_RESET)) begin
        perf_bubbles_o <= sat_inc(perf_bubbles_o);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected deliveries are queued when an imem
// response is driven and popped whenever the DUT emits decoder_next.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic                  clk;
  logic                  arstn;
  logic                  req_valid;
  logic                  ready;
  logic [31:0]           req_addr;
  logic                  rsp_valid;
  logic [31:0]           rsp_data;
  logic                  stall;
  logic                  branch;
  logic [31:0]           target;
  fetch_to_decoder_req_t req;

  logic                  w_req_valid;
  logic                  w_ready;
  logic [31:0]           w_req_addr;
  logic                  w_rsp_valid;
  logic [31:0]           w_rsp_data;
  fetch_to_decoder_req_t w_req;
  logic                  w_done;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles, w_perf_fetched, w_perf_bubbles;
`endif

  int n_checks = 0;
  int n_errors = 0;
  fetch_to_decoder_req_t sb[$];

  fetch_unit dut (
    .clk                    (clk),
    .arstn                  (arstn),
    .imem_req_valid_o       (req_valid),
    .imem_req_ready_i       (ready),
    .imem_req_addr_o        (req_addr),
    .imem_rsp_valid_i       (rsp_valid),
    .imem_rsp_data_i        (rsp_data),
    .stall_i                (stall),
    .branch_valid_i         (branch),
    .branch_target_i        (target),
    .fetch_to_decoder_req_o (req)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched_o         (perf_fetched),
    .perf_bubbles_o         (perf_bubbles)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk                    (clk),
    .arstn                  (arstn),
    .imem_req_valid_o       (w_req_valid),
    .imem_req_ready_i       (w_ready),
    .imem_req_addr_o        (w_req_addr),
    .imem_rsp_valid_i       (w_rsp_valid),
    .imem_rsp_data_i        (w_rsp_data),
    .stall_i                (1'b0),
    .branch_valid_i         (1'b0),
    .branch_target_i        (32'h0),
    .fetch_to_decoder_req_o (w_req)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched_o         (w_perf_fetched),
    .perf_bubbles_o         (w_perf_bubbles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // One request/response round trip: request seen, response one cycle later, delivered same cycle.
  task automatic fetch_one(input logic [31:0] a);
    @(negedge clk);
    chk("req_valid", 64'(req_valid), 64'(1));
    chk("req_addr", 64'(req_addr), 64'(a));
    chk("req_cycle_nope", 64'(req.decoder_state), 64'(decoder_nope));
    next_cyc();
    rsp_valid = 1'b1;
    rsp_data  = mem(a);
    sb.push_back('{decoder_state: decoder_next, inst: mem(a), pc: a});
    @(negedge clk);
    chk("deliver_next", 64'(req.decoder_state), 64'(decoder_next));
    next_cyc();
    rsp_valid = 1'b0;
  endtask

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    if (arstn === 1'b1 && req.decoder_state == decoder_next) begin : mon
      fetch_to_decoder_req_t e;
      if (sb.size() == 0) begin
        chk("spurious_next", 64'(req.decoder_state), 64'(decoder_nope));
      end else begin
        e = sb.pop_front();
        chk("deliver_inst", 64'(req.inst), 64'(e.inst));
        chk("deliver_pc", 64'(req.pc), 64'(e.pc));
      end
    end
  end

  // Wrap-around instance: two fetches starting at 0xFFFFFFFC.
  initial begin : wrap_thread
    int n;
    logic [31:0] exp_a;
    w_ready     = 1'b1;
    w_rsp_valid = 1'b0;
    w_rsp_data  = '0;
    w_done      = 1'b0;
    n = 0;
    wait (arstn === 1'b1);
    for (int t = 0; t < 20 && n < 2; t++) begin
      @(negedge clk);
      if (w_req_valid) begin
        exp_a = (n == 0) ? 32'hFFFF_FFFC : 32'h0;
        chk("wrap_addr", 64'(w_req_addr), 64'(exp_a));
        next_cyc();
        w_rsp_valid = 1'b1;
        w_rsp_data  = mem(exp_a);
        @(negedge clk);
        chk("wrap_state", 64'(w_req.decoder_state), 64'(decoder_next));
        chk("wrap_pc", 64'(w_req.pc), 64'(exp_a));
        next_cyc();
        w_rsp_valid = 1'b0;
        n++;
      end
    end
    w_done = (n == 2);
  end

  initial begin
    arstn = 1'b0; ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    stall = 1'b0; branch = 1'b0; target = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(req_valid), 64'(0));
    chk("rst_state", 64'(req.decoder_state), 64'(decoder_nope));
    chk("rst_inst", 64'(req.inst), 64'(0));
    chk("rst_pc", 64'(req.pc), 64'(0));
    next_cyc();
    arstn = 1'b1;
    @(negedge clk);
    chk("sreset_no_req", 64'(req_valid), 64'(0));
    next_cyc();

    // Straight-line fetch
    fetch_one(32'h0);
    fetch_one(32'h4);
    fetch_one(32'h8);

    // Stall while the response returns: keep, buffered, then drained in order
    stall = 1'b1;
    @(negedge clk);
    chk("stall_req_state", 64'(req.decoder_state), 64'(decoder_keep));
    chk("stall_req_addr", 64'(req_addr), 64'(32'hC));
    next_cyc();
    rsp_valid = 1'b1;
    rsp_data  = mem(32'hC);
    sb.push_back('{decoder_state: decoder_next, inst: mem(32'hC), pc: 32'hC});
    @(negedge clk);
    chk("stall_rsp_keep", 64'(req.decoder_state), 64'(decoder_keep));
    next_cyc();
    rsp_valid = 1'b0;
    @(negedge clk);
    chk("buf_full_no_req", 64'(req_valid), 64'(0));
    chk("buf_full_keep", 64'(req.decoder_state), 64'(decoder_keep));
    next_cyc();
    stall = 1'b0;
    @(negedge clk);
    chk("buf_drain_next", 64'(req.decoder_state), 64'(decoder_next));
    next_cyc();
    fetch_one(32'h10);

    // Branch while a request is outstanding
    @(negedge clk);
    chk("pre_branch_addr", 64'(req_addr), 64'(32'h14));
    next_cyc();
    branch = 1'b1;
    target = 32'h100;
    @(negedge clk);
    chk("branch_nope", 64'(req.decoder_state), 64'(decoder_nope));
    next_cyc();
    branch    = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = mem(32'h14);
    @(negedge clk);
    chk("killed_rsp_nope", 64'(req.decoder_state), 64'(decoder_nope));
    next_cyc();
    rsp_valid = 1'b0;
    fetch_one(32'h100);

    // Branch and stall together with the buffer full
    stall = 1'b1;
    @(negedge clk);
    chk("b4_req_addr", 64'(req_addr), 64'(32'h104));
    next_cyc();
    rsp_valid = 1'b1;
    rsp_data  = mem(32'h104);
    @(negedge clk);
    chk("b4_buffered_keep", 64'(req.decoder_state), 64'(decoder_keep));
    next_cyc();
    rsp_valid = 1'b0;
    branch    = 1'b1;
    target    = 32'h200;
    @(negedge clk);
    chk("b4_branch_nope", 64'(req.decoder_state), 64'(decoder_nope));
    chk("b4_no_req", 64'(req_valid), 64'(0));
    next_cyc();
    branch = 1'b0;
    stall  = 1'b0;
    fetch_one(32'h200);

    // Reset asserted in S_WAIT, late response after release
    @(negedge clk);
    chk("pre_rst_addr", 64'(req_addr), 64'(32'h204));
    next_cyc();
    arstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(req_valid), 64'(0));
    chk("mid_rst_state", 64'(req.decoder_state), 64'(decoder_nope));
    next_cyc();
    arstn     = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = mem(32'h204);
    @(negedge clk);
    chk("late_rsp_sreset", 64'(req.decoder_state), 64'(decoder_nope));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_rst", 64'(perf_fetched), 64'(0));
    chk("perf_bubbles_rst", 64'(perf_bubbles), 64'(0));
`endif
    next_cyc();
    ready = 1'b0;
    @(negedge clk);
    chk("late_rsp_sreq", 64'(req.decoder_state), 64'(decoder_nope));
    chk("post_rst_addr", 64'(req_addr), 64'(32'h0));
    next_cyc();
    ready     = 1'b1;
    rsp_valid = 1'b0;
    fetch_one(32'h0);
    fetch_one(32'h4);
    fetch_one(32'h8);
`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    chk("perf_fetched_3", 64'(perf_fetched), 64'(3));
`endif

    for (int i = 0; i < 50 && !w_done; i++) @(posedge clk);
    chk("wrap_done", 64'(w_done), 64'(1));
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
